// File: rtl/fetch_unit.sv
// fetch_unit: F stage PC register with prioritized redirects and AdEL fetch checking
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        d_is_branch,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_o,
  output logic [31:0] pc8_o,
  output logic [31:0] cause_o,
  output logic [31:0] pc_o
);
  logic [31:0] pc;
  logic        bd_q;
  logic        adel;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      bd_q <= 1'b0;
    end else if (exc_req || eret_req) begin
      pc   <= exc_req ? HANDLER_PC : epc;
      bd_q <= 1'b0;
    end else if (en) begin
      pc   <= br_take ? br_target : pc + 32'd4;
      bd_q <= d_is_branch;
    end
  end
  always_comb begin
    adel    = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
    instr_o = adel ? 32'h0 : im_rdata;
    cause_o = {bd_q, 24'b0, adel ? EXC_ADEL : 5'd0, 2'b00};
    pc8_o   = pc + 32'd8;
    im_addr = pc;
    pc_o    = pc;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a spec-level reference model checked every cycle
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, en, exc_req, eret_req, br_take, d_is_branch;
  logic [31:0] epc, br_target, im_rdata, im_addr, instr_o, pc8_o, cause_o, pc_o;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_valid = 1'b0;

  always #5 clk = ~clk;
  assign im_rdata = 32'h2408_0000 | {16'h0, im_addr[15:0]};

  fetch_unit dut (
    .clk(clk), .rst(rst), .en(en), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .br_take(br_take), .br_target(br_target), .d_is_branch(d_is_branch),
    .im_addr(im_addr), .im_rdata(im_rdata), .instr_o(instr_o), .pc8_o(pc8_o),
    .cause_o(cause_o), .pc_o(pc_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next PC chosen by the redirect priority list
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0000_3000;
      m_bd = 1'b0;
      m_valid = 1'b1;
    end else if (exc_req) begin
      m_pc = 32'h0000_4180;
      m_bd = 1'b0;
    end else if (eret_req) begin
      m_pc = epc;
      m_bd = 1'b0;
    end else if (en) begin
      m_bd = d_is_branch;
      m_pc = br_take ? br_target : m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      automatic logic legal = (m_pc % 4 == 0) && (m_pc >= 32'h3000) && (m_pc <= 32'h6FFC);
      chk("m_im_addr", im_addr, m_pc);
      chk("m_pc_o", pc_o, m_pc);
      chk("m_pc8", pc8_o, m_pc + 32'd8);
      chk("m_instr", instr_o, legal ? im_rdata : 32'h0);
      chk("m_cause", cause_o, (m_bd ? 32'h8000_0000 : 32'h0) | (legal ? 32'h0 : 32'h10));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #7;
  endtask

  task automatic jump(input logic [31:0] t, input logic bd);
    br_take = 1'b1; br_target = t; d_is_branch = bd;
    cyc();
    br_take = 1'b0; d_is_branch = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; exc_req = 1'b0; eret_req = 1'b0; br_take = 1'b0;
    d_is_branch = 1'b0; epc = 32'h0; br_target = 32'h0;
    cyc();
    chk("rst_addr", im_addr, 32'h3000);
    chk("rst_pc8", pc8_o, 32'h3008);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_instr", instr_o, 32'h2408_3000);
    rst = 1'b0;
    cyc(); chk("seq1", im_addr, 32'h3004);
    cyc(); chk("seq2", im_addr, 32'h3008);
    cyc(); chk("seq3", im_addr, 32'h300C); chk("seq3_pc8", pc8_o, 32'h3014);
    cyc(); chk("seq4", pc_o, 32'h3010);
    en = 1'b0; br_take = 1'b1; br_target = 32'h3100;
    cyc(); chk("stall1", pc_o, 32'h3010);
    cyc(); chk("stall2", pc_o, 32'h3010);
    en = 1'b1;
    cyc(); chk("stall_br", pc_o, 32'h3100);
    br_take = 1'b0;
    jump(32'h3020, 1'b0);
    jump(32'h3201, 1'b1);
    chk("mis_pc", pc_o, 32'h3201);
    chk("mis_instr", instr_o, 32'h0);
    chk("mis_cause", cause_o, 32'h8000_0010);
    chk("mis_pc8", pc8_o, 32'h3209);
    jump(32'h3040, 1'b1);
    chk("bd_cause", cause_o, 32'h8000_0000);
    exc_req = 1'b1; eret_req = 1'b1; br_take = 1'b1; en = 1'b0; epc = 32'h3058;
    cyc(); chk("exc_pc", pc_o, 32'h4180); chk("exc_cause", cause_o, 32'h0);
    exc_req = 1'b0; br_take = 1'b0; en = 1'b1;
    cyc(); chk("eret_pc", pc_o, 32'h3058);
    eret_req = 1'b0;
    cyc(); chk("eret_seq", pc_o, 32'h305C);
    jump(32'h6FFC, 1'b0);
    chk("hi_cause", cause_o, 32'h0); chk("hi_instr", instr_o, 32'h2408_6FFC);
    cyc(); chk("past_pc", pc_o, 32'h7000);
    chk("past_cause", cause_o, 32'h10); chk("past_instr", instr_o, 32'h0);
    jump(32'hFFFF_FFFC, 1'b0);
    cyc(); chk("wrap_pc", pc_o, 32'h0); chk("wrap_pc8", pc8_o, 32'h8);
    chk("wrap_cause", cause_o, 32'h10);
    jump(32'h3500, 1'b1);
    chk("pre_rst_cause", cause_o, 32'h8000_0000);
    en = 1'b0; rst = 1'b1;
    cyc(); chk("mid_rst_pc", pc_o, 32'h3000); chk("mid_rst_cause", cause_o, 32'h0);
    rst = 1'b0; en = 1'b1;
    cyc(); chk("post_rst", pc_o, 32'h3004);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
